// File: rtl/mux_4x_n_bit.sv
// rtl/mux_4x_n_bit.sv - 4-to-1 N-bit multiplexer with registered output and valid qualifier
module mux_4x_n_bit #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic [BUS_WIDTH-1:0] c,
    input  logic [BUS_WIDTH-1:0] d,
    input  logic [1:0]           sel,
    input  logic                 valid_in,
    output logic [BUS_WIDTH-1:0] y,
    output logic                 valid_out
);

    logic [BUS_WIDTH-1:0] sel_data;

    always_comb begin
        sel_data = a;
        case (sel)
            2'd0: sel_data = a;
            2'd1: sel_data = b;
            2'd2: sel_data = c;
            2'd3: sel_data = d;
            default: sel_data = a;
        endcase
    end

    // y only moves on a qualified transfer; valid_out tracks valid_in every edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y         <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                y <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_mux_4x_n_bit.sv
// tb/tb_mux_4x_n_bit.sv - directed self-checking bench for mux_4x_n_bit at widths 8, 1 and 32
module tb_mux_4x_n_bit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic        valid_in;

    logic [7:0]  a8, b8, c8, d8, y8;
    logic        vo8;
    logic        a1, b1, c1, d1, y1;
    logic        vo1;
    logic [31:0] a32, b32, c32, d32, y32;
    logic        vo32;

    int n_checks;
    int n_fail;

    mux_4x_n_bit #(.BUS_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .d(d8),
        .sel(sel), .valid_in(valid_in), .y(y8), .valid_out(vo8)
    );

    mux_4x_n_bit #(.BUS_WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .d(d1),
        .sel(sel), .valid_in(valid_in), .y(y1), .valid_out(vo1)
    );

    mux_4x_n_bit #(.BUS_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .c(c32), .d(d32),
        .sel(sel), .valid_in(valid_in), .y(y32), .valid_out(vo32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b1; sel = 2'd0; a8 = 8'hFF;
        a1 = 1'b1; a32 = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (y8 !== 8'h00) begin
                n_fail++; $display("FAIL reset_y8 cycle %0d: got %h want 00", i, y8);
            end
            n_checks++;
            if (vo8 !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid8 cycle %0d: got %b want 0", i, vo8);
            end
            n_checks++;
            if (y1 !== 1'b0 || y32 !== 32'h0 || vo1 !== 1'b0 || vo32 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_wide cycle %0d: got y1=%b y32=%h vo1=%b vo32=%b want 0", i, y1, y32, vo1, vo32);
            end
        end
    endtask

    task automatic test_each_select();
        logic [7:0] exp_y [4];
        exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h33; exp_y[3] = 8'h44;
        rst_n = 1'b1; valid_in = 1'b1;
        a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            n_checks++;
            if (y8 !== exp_y[i]) begin
                n_fail++; $display("FAIL select_y sel=%0d: got %h want %h", i, y8, exp_y[i]);
            end
            n_checks++;
            if (vo8 !== 1'b1) begin
                n_fail++; $display("FAIL select_valid sel=%0d: got %b want 1", i, vo8);
            end
        end
    endtask

    task automatic test_hold();
        valid_in = 1'b0; sel = 2'd0; a8 = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (y8 !== 8'h44) begin
                n_fail++; $display("FAIL hold_y cycle %0d: got %h want 44", i, y8);
            end
            n_checks++;
            if (vo8 !== 1'b0) begin
                n_fail++; $display("FAIL hold_valid cycle %0d: got %b want 0", i, vo8);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp_y;
        valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
            sel = 2'($urandom_range(0, 3));
            case (sel)
                2'd0: exp_y = a8;
                2'd1: exp_y = b8;
                2'd2: exp_y = c8;
                default: exp_y = d8;
            endcase
            tick();
            n_checks++;
            if (y8 !== exp_y || vo8 !== 1'b1) begin
                n_fail++;
                $display("FAIL random_y cycle %0d sel=%0d: got y=%h v=%b want y=%h v=1", i, sel, y8, vo8, exp_y);
            end
        end
    endtask

    task automatic test_reset_midstream();
        valid_in = 1'b1; sel = 2'd2; c8 = 8'h5A; a8 = 8'h01; b8 = 8'h02; d8 = 8'h04;
        tick();
        n_checks++;
        if (y8 !== 8'h5A) begin
            n_fail++; $display("FAIL midrst_pre: got %h want 5a", y8);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (y8 !== 8'h00 || vo8 !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flush: got y=%h v=%b want y=00 v=0", y8, vo8);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (y8 !== 8'h5A || vo8 !== 1'b1) begin
            n_fail++; $display("FAIL midrst_release: got y=%h v=%b want y=5a v=1", y8, vo8);
        end
    endtask

    task automatic test_width_sweep();
        logic        exp1 [4];
        logic [31:0] exp32 [4];
        exp1[0] = 1'b0; exp1[1] = 1'b1; exp1[2] = 1'b0; exp1[3] = 1'b1;
        exp32[0] = 32'h0123_4567; exp32[1] = 32'h89AB_CDEF;
        exp32[2] = 32'h8000_0001; exp32[3] = 32'hDEAD_BEEF;
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0; d1 = 1'b1;
        a32 = 32'h0123_4567; b32 = 32'h89AB_CDEF; c32 = 32'h8000_0001; d32 = 32'hDEAD_BEEF;
        rst_n = 1'b1; valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            n_checks++;
            if (y1 !== exp1[i] || vo1 !== 1'b1) begin
                n_fail++; $display("FAIL width1 sel=%0d: got y=%b v=%b want y=%b v=1", i, y1, vo1, exp1[i]);
            end
            n_checks++;
            if (y32 !== exp32[i] || vo32 !== 1'b1) begin
                n_fail++; $display("FAIL width32 sel=%0d: got y=%h v=%b want y=%h v=1", i, y32, vo32, exp32[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_y [4];
        exp_y[0] = 8'hD4; exp_y[1] = 8'hC3; exp_y[2] = 8'hB2; exp_y[3] = 8'hA1;
        a8 = 8'hA1; b8 = 8'hB2; c8 = 8'hC3; d8 = 8'hD4;
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(3 - i);
            tick();
            n_checks++;
            if (y8 !== exp_y[i] || vo8 !== 1'b1) begin
                n_fail++; $display("FAIL b2b cycle %0d: got y=%h v=%b want y=%h v=1", i, y8, vo8, exp_y[i]);
            end
        end
        valid_in = 1'b0;
        tick();
        n_checks++;
        if (y8 !== 8'hA1 || vo8 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_tail: got y=%h v=%b want y=a1 v=0", y8, vo8);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; valid_in = 1'b0; sel = 2'd0;
        a8 = '0; b8 = '0; c8 = '0; d8 = '0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
        a32 = '0; b32 = '0; c32 = '0; d32 = '0;
        test_reset();
        test_each_select();
        test_hold();
        test_random_stream();
        test_reset_midstream();
        test_width_sweep();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
